// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser and the vending machine that feeds it:
// change codes, dispenser FSM encoding and default timing parameters.
package change_dispenser_pkg;

  typedef logic [1:0] change_t;

  localparam change_t CHG_NONE = 2'b00;
  localparam change_t CHG_RS5  = 2'b01;
  localparam change_t CHG_RS10 = 2'b10;
  localparam change_t CHG_RSVD = 2'b11;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 1000;
  localparam int DEFAULT_GAP     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRIVE = 3'd2,
    ST_GAP   = 3'd3,
    ST_JAM   = 3'd4
  } state_t;

  function automatic logic is_coin_req(input change_t c);
    return (c == CHG_RS5) || (c == CHG_RS10);
  endfunction

endpackage

// File: rtl/change_fifo.sv
// Synchronous DEPTH x WIDTH request FIFO with occupancy counter; read data is combinational from the head.
// Latency: push visible as non-empty the next cycle; a push while full is refused unless a pop happens in the same cycle.
module change_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             push_ok_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i && !empty_o;
  // A pop frees the slot this same cycle, so a full FIFO still takes the push.
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_ok_o = do_push;
  assign rdata_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues Rs5/Rs10 change requests and drives the coin hoppers one coin at a time.
// Latency: first drive 3 cycles after the request edge; requests arriving while the queue is full are dropped (sticky overflow).
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int GAP     = DEFAULT_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] change,
  input  logic       coin_sense,
  input  logic       empty10,
  input  logic       clear_jam,
  output logic       coin5_drive,
  output logic       coin10_drive,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic       jam
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  state_t        state_q, state_d;
  logic [1:0]    coins_q, coins_d;
  logic          sel10_q, sel10_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          drv5_q, drv5_d;
  logic          drv10_q, drv10_d;
  logic          ovf_q, ovf_d;

  logic          push_req, push_ok, fifo_pop, fifo_full, fifo_empty;
  change_t       head;

  assign push_req = is_coin_req(change);

  change_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (push_req),
    .wdata_i   (change),
    .pop_i     (fifo_pop),
    .rdata_o   (head),
    .push_ok_o (push_ok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign ovf_d = ovf_q || (push_req && !push_ok);

  always_comb begin
    state_d  = state_q;
    coins_d  = coins_q;
    sel10_d  = sel10_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        fifo_pop = 1'b1;
        tmo_d    = '0;
        state_d  = ST_DRIVE;
        // An empty Rs10 hopper is covered by paying out two Rs5 coins instead.
        if (head == CHG_RS10 && !empty10) begin
          coins_d = 2'd1;
          sel10_d = 1'b1;
        end else if (head == CHG_RS10) begin
          coins_d = 2'd2;
          sel10_d = 1'b0;
        end else begin
          coins_d = 2'd1;
          sel10_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (coin_sense) begin
          coins_d = coins_q - 2'd1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          coins_d = '0;
          state_d = ST_JAM;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (coins_q != 2'd0) begin
            tmo_d   = '0;
            state_d = ST_DRIVE;
          end else if (!fifo_empty) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_JAM: begin
        if (clear_jam) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Drives follow the next state so they are registered yet line up exactly with DRIVE.
  assign drv5_d  = (state_d == ST_DRIVE) && !sel10_d;
  assign drv10_d = (state_d == ST_DRIVE) && sel10_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      coins_q <= '0;
      sel10_q <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
      drv5_q  <= 1'b0;
      drv10_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      coins_q <= coins_d;
      sel10_q <= sel10_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      drv5_q  <= drv5_d;
      drv10_q <= drv10_d;
      ovf_q   <= ovf_d;
    end
  end

  assign coin5_drive  = drv5_q;
  assign coin10_drive = drv10_q;
  assign busy         = !fifo_empty || !(state_q == ST_IDLE || state_q == ST_JAM);
  assign full         = fifo_full;
  assign overflow     = ovf_q;
  assign jam          = (state_q == ST_JAM);

  a_drive_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(coin5_drive && coin10_drive));
  a_drive_in_drive : assert property (@(posedge clk) disable iff (!rst)
    (coin5_drive || coin10_drive) |-> (state_q == ST_DRIVE));

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: queued expected coins, hopper responder and a drive monitor.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
  localparam int GAP     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] change = CHG_NONE;
  logic       coin_sense = 1'b0;
  logic       empty10 = 1'b0;
  logic       clear_jam = 1'b0;
  logic       coin5_drive, coin10_drive, busy, full, overflow, jam;

  typedef struct {
    int kind;
    bit first;
    bit pair2;
  } coin_t;

  coin_t exp_q[$];
  int checks = 0, passes = 0;
  int issued = 0, started = 0, both_high = 0;
  bit hop_stall = 0, hop_rand = 0, spur_en = 0;
  int hop_fixed = 3, hop_d = 3, hi_seen = 0, exp_width = 0;
  int hi_cnt = 0, low_cnt = 0;
  bit prev_on = 0;

  change_dispenser #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .change       (change),
    .coin_sense   (coin_sense),
    .empty10      (empty10),
    .clear_jam    (clear_jam),
    .coin5_drive  (coin5_drive),
    .coin10_drive (coin10_drive),
    .busy         (busy),
    .full         (full),
    .overflow     (overflow),
    .jam          (jam)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endtask

  // Reference model: the coins a request must produce given the Rs10 hopper level.
  task automatic expect_req(input logic [1:0] code, input logic e10);
    coin_t c;
    if (code == CHG_RS5) begin
      c = '{5, 1'b1, 1'b0}; exp_q.push_back(c);
    end else if (code == CHG_RS10 && e10) begin
      c = '{5, 1'b1, 1'b0}; exp_q.push_back(c);
      c = '{5, 1'b0, 1'b1}; exp_q.push_back(c);
    end else if (code == CHG_RS10) begin
      c = '{10, 1'b1, 1'b0}; exp_q.push_back(c);
    end
  endtask

  task automatic send(input logic [1:0] code);
    change = code;
    expect_req(code, empty10);
    @(negedge clk);
    change = CHG_NONE;
  endtask

  task automatic wait_on(input bit want, input int budget, input string name);
    int n = 0;
    while ((coin5_drive | coin10_drive) != want && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(coin5_drive | coin10_drive), int'(want));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"idle_busy_", name}, int'(busy), 0);
    chk({"idle_pending_", name}, exp_q.size(), 0);
  endtask

  // Hopper model: ejects a coin a few cycles into each drive unless stalled.
  always @(negedge clk) begin
    if (!rst) begin
      coin_sense = 1'b0;
      hi_seen = 0;
    end else if (coin5_drive || coin10_drive) begin
      hi_seen++;
      if (!hop_stall && hi_seen >= hop_d + 1) begin
        coin_sense = 1'b1;
        exp_width = hi_seen;
      end else begin
        coin_sense = 1'b0;
        exp_width = TIMEOUT;
      end
    end else begin
      hi_seen = 0;
      hop_d = hop_rand ? int'($urandom_range(0, 5)) : hop_fixed;
      coin_sense = spur_en && ($urandom_range(0, 3) == 0);
    end
  end

  always @(negedge clk) begin : monitor
    coin_t c;
    logic on;
    int kind;
    if (!rst) begin
      prev_on = 0;
      hi_cnt = 0;
      low_cnt = 0;
    end else begin
      on = coin5_drive | coin10_drive;
      kind = coin10_drive ? 10 : 5;
      if (coin5_drive && coin10_drive) both_high++;
      if (on && !prev_on) begin
        if (exp_q.size() == 0) chk("unexpected_coin", kind, 0);
        else begin
          c = exp_q.pop_front();
          chk("coin_kind", kind, c.kind);
          if (c.pair2) chk("pair_gap", low_cnt, GAP);
          if (c.first) started++;
        end
        hi_cnt = 1;
      end else if (on) begin
        hi_cnt++;
      end else if (prev_on) begin
        chk("drive_width", hi_cnt, exp_width);
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      prev_on = on;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_on, model_cnt;
    bit ovf_m;
    logic [1:0] code;

    repeat (3) @(negedge clk);
    chk("rst_coin5", int'(coin5_drive), 0);
    chk("rst_coin10", int'(coin10_drive), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_jam", int'(jam), 0);

    // Single Rs5 accepted on the first edge after reset release.
    hop_rand = 0; hop_fixed = 3;
    rst = 1'b1;
    change = CHG_RS5;
    expect_req(CHG_RS5, empty10);
    @(negedge clk);
    change = CHG_NONE;
    chk("first_push_busy", int'(busy), 1);
    chk("drive_idle_cycle", int'(coin5_drive), 0);
    @(negedge clk);
    chk("drive_load_cycle", int'(coin5_drive), 0);
    @(negedge clk);
    chk("drive_latency", int'(coin5_drive), 1);
    wait_on(1'b0, 20, "rs5_drive_off");
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_tail", n, GAP);
    chk("rs5_overflow", int'(overflow), 0);
    chk("rs5_jam", int'(jam), 0);

    // Rs10 with and without the Rs10 hopper available.
    empty10 = 1'b0;
    send(CHG_RS10);
    wait_idle(100, "rs10");
    empty10 = 1'b1;
    send(CHG_RS10);
    wait_idle(100, "rs10_split");
    empty10 = 1'b0;

    // Stalled hopper: fill the queue and push past it.
    hop_stall = 1;
    send(CHG_RS5);
    wait_on(1'b1, 10, "ovf_first_drive");
    model_cnt = 0; ovf_m = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      change = CHG_RS5;
      if (model_cnt < DEPTH) begin
        model_cnt++;
        expect_req(CHG_RS5, empty10);
      end else ovf_m = 1;
      @(negedge clk);
      chk("full_track", int'(full), int'(model_cnt == DEPTH));
      chk("ovf_track", int'(overflow), int'(ovf_m));
    end
    change = CHG_NONE;
    hop_stall = 0;
    wait_idle(400, "overflow");
    chk("ovf_sticky", int'(overflow), 1);

    // Timeout into JAM, queue a request meanwhile, then clear.
    hop_stall = 1;
    send(CHG_RS5);
    wait_on(1'b1, 10, "jam_drive_on");
    wait_on(1'b0, TIMEOUT + 5, "jam_drive_off");
    chk("jam_set", int'(jam), 1);
    send(CHG_RS10);
    n_on = 0;
    repeat (8) begin
      @(negedge clk);
      if (coin5_drive || coin10_drive) n_on++;
    end
    chk("jam_no_drive", n_on, 0);
    chk("jam_busy", int'(busy), 1);
    chk("jam_held", int'(jam), 1);
    hop_stall = 0;
    clear_jam = 1'b1;
    @(negedge clk);
    clear_jam = 1'b0;
    chk("jam_cleared", int'(jam), 0);
    wait_idle(100, "after_jam");

    // Reset in the middle of a drive with a queued entry behind it.
    hop_stall = 1;
    send(CHG_RS5);
    send(CHG_RS5);
    wait_on(1'b1, 10, "rst_drive_on");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_coin5", int'(coin5_drive), 0);
    chk("midrst_coin10", int'(coin10_drive), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_jam", int'(jam), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hop_stall = 0;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_full", int'(full), 0);

    // Stray sensor pulses and reserved/none codes while idle.
    spur_en = 1;
    n = 0;
    repeat (16) begin
      change = ($urandom_range(0, 1) == 1) ? CHG_RSVD : CHG_NONE;
      @(negedge clk);
      if (busy || coin5_drive || coin10_drive) n++;
    end
    change = CHG_NONE;
    chk("spurious_activity", n, 0);
    chk("spurious_overflow", int'(overflow), 0);

    // Randomised traffic, throttled so the queue can never overflow.
    hop_rand = 1;
    issued = 0; started = 0;
    for (int r = 0; r < 60; r++) begin
      if (r % 15 == 0) begin
        wait_idle(600, "batch");
        empty10 = 1'($urandom_range(0, 1));
        issued = 0; started = 0;
      end
      n = 0;
      while (issued - started >= DEPTH && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("throttle", int'(issued - started < DEPTH), 1);
      repeat ($urandom_range(0, 3)) begin
        change = ($urandom_range(0, 1) == 1) ? CHG_RSVD : CHG_NONE;
        clear_jam = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      clear_jam = 1'b0;
      code = ($urandom_range(0, 1) == 1) ? CHG_RS10 : CHG_RS5;
      send(code);
      issued++;
    end
    wait_idle(800, "random_end");
    chk("random_overflow", int'(overflow), 0);
    chk("random_jam", int'(jam), 0);
    chk("both_drives_high", both_high, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter DEPTH, 4, change-request FIFO entries (power of 2, 2..16).
REQ-002 Parameter TIMEOUT, 1000, max cycles a hopper drive may wait for a coin-sensor pulse.
REQ-003 Parameter GAP, 4, idle cycles between consecutive hopper drives.
REQ-004 clk  input  1  rising-edge clock, single domain.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 change  input  2  change code from the vending machine: 00 none, 01 Rs5, 10 Rs10, 11 reserved.
REQ-007 coin_sense  input  1  hopper sensor, one-cycle pulse per ejected coin, already synchronised.
REQ-008 empty10  input  1  Rs10 hopper empty (level).
REQ-009 clear_jam  input  1  one-cycle pulse; acknowledges a jam.
REQ-010 coin5_drive  output  1  Rs5 hopper motor enable.
REQ-011 coin10_drive  output  1  Rs10 hopper motor enable.
REQ-012 busy  output  1  FIFO non-empty or dispense in progress.
REQ-013 full  output  1  FIFO holds DEPTH entries.
REQ-014 overflow  output  1  sticky; a request was dropped.
REQ-015 jam  output  1  sticky; drive timed out.

Function
REQ-016 Each cycle with change = 01 or 10 and FIFO not full SHALL push one entry; 00 and 11 SHALL push nothing.
REQ-017 A request arriving while full SHALL be dropped and SHALL set overflow until reset.
REQ-018 Simultaneous push and pop when full SHALL both take effect: no drop, occupancy unchanged.
REQ-019 FSM states: IDLE, LOAD, DRIVE, GAP, JAM.
REQ-020 IDLE -> LOAD when FIFO non-empty; LOAD pops one entry and computes coins_left.
REQ-021 Rs5 entry: one Rs5 coin. Rs10 entry with empty10=0: one Rs10 coin. Rs10 entry with empty10=1 (sampled in LOAD): two Rs5 coins.
REQ-022 DRIVE asserts exactly one of coin5_drive/coin10_drive, registered, from the cycle after LOAD.
REQ-023 In DRIVE, coin_sense decrements coins_left and deasserts the drive the next cycle; the state then goes to GAP.
REQ-024 GAP lasts exactly GAP cycles with both drives low, then -> DRIVE if coins_left > 0, LOAD if FIFO non-empty, else IDLE.
REQ-025 A timeout counter SHALL reset on DRIVE entry; reaching TIMEOUT cycles without coin_sense -> JAM.
REQ-026 JAM: both drives low, jam=1, FIFO keeps accepting per REQ-016/017, current entry abandoned.
REQ-027 clear_jam in JAM SHALL clear jam and go to IDLE; clear_jam in any other state SHALL be ignored.
REQ-028 coin_sense outside DRIVE SHALL be ignored; a second pulse in the same DRIVE cycle window SHALL NOT count twice.
REQ-029 Drives SHALL never both be high; at most one coin is outstanding.
REQ-030 busy = FIFO non-empty OR state not in {IDLE, JAM}.

Reset
REQ-031 rst low SHALL immediately force coin5_drive=0, coin10_drive=0, busy=0, full=0, overflow=0, jam=0, state IDLE, FIFO empty, counters zero, including mid-DRIVE.
REQ-032 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-033 Shared package: change code constants (NONE, RS5, RS10), FSM state encoding, default TIMEOUT/GAP values; the vending machine uses the same change constants.
REQ-034 One sub-module, change_fifo (synchronous FIFO, DEPTH x 2 bits, full/empty, occupancy counter); the FSM and timers stay in change_dispenser.

Verification
REQ-035 Reset, then change=01 for 1 cycle, coin_sense 3 cycles after drive rises -> coin5_drive high for 4 cycles, busy falls after GAP, no flags.
REQ-036 change=10 with empty10=0 -> single coin10_drive; repeat with empty10=1 -> two coin5_drive pulses separated by exactly GAP low cycles.
REQ-037 DEPTH+2 back-to-back Rs5 requests with hopper stalled -> full after DEPTH pushes, overflow=1, exactly DEPTH coins after releasing coin_sense.
REQ-038 No coin_sense for TIMEOUT cycles -> drive drops, jam=1; new request queued; clear_jam -> jam=0, queued entry dispensed.
REQ-039 rst asserted mid-DRIVE -> drives low in the same cycle, all outputs zero, FIFO empty after release.
REQ-040 coin_sense pulses in IDLE and GAP, and change=11 -> no state change, no push, no drive.
